// File: rtl/rns_fir_channel.sv
// rns_fir_channel
// Single-modulus residue-number-system FIR channel. Accepts residue samples
// over a valid/ready handshake and evaluates a TAPS-tap FIR with one
// multiply-accumulate per cycle, with all arithmetic modulo MOD. Each result
// goes into a DEPTH-entry circular buffer, which is read back through a
// registered address/data port.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   in_valid      sample offered
//   in_ready      channel can accept a sample (high only in IDLE)
//   in_data       input residue, reduced mod MOD on acceptance
//   coef_we       coefficient write strobe (honoured only in IDLE)
//   coef_addr     tap index for the coefficient write
//   coef_data     coefficient value, stored mod MOD
//   reg_addr      result buffer read address
//   reg_data      buffer contents at reg_addr, one cycle later
//   done          one-cycle pulse after each result write
//   result_count  number of results written, saturating at DEPTH
//   wrapped       sticky flag, set when a write overwrites an older result
module rns_fir_channel #(
  parameter int MOD   = 7,
  parameter int W     = $clog2(MOD),
  parameter int TAPS  = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [W-1:0]             coef_data,
  input  logic [$clog2(DEPTH)-1:0] reg_addr,
  output logic [W-1:0]             reg_data,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   result_count,
  output logic                     wrapped
);

  localparam int KW      = $clog2(TAPS);
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int TAPS_M1 = TAPS - 1;

  localparam logic [W:0]     MOD_W1 = MOD[W:0];
  localparam logic [2*W-1:0] MOD_P  = MOD[2*W-1:0];
  localparam logic [KW-1:0]  K_LAST = TAPS_M1[KW-1:0];
  localparam logic [CW-1:0]  FULL   = DEPTH[CW-1:0];

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  state_t state, next_state;

  logic [W-1:0]  x       [TAPS];
  logic [W-1:0]  h       [TAPS];
  logic [W-1:0]  res_mem [DEPTH];
  logic [W-1:0]  acc;
  logic [KW-1:0] k;
  logic [AW-1:0] wptr;

  logic           accept;
  logic           coef_addr_ok;
  logic [2*W-1:0] prod;
  logic [W-1:0]   prod_mod;
  logic [W:0]     sum_ext;
  logic [W-1:0]   acc_next;

  // Because 2^W < 2*MOD, any W-bit value is at most one modulus away from
  // its residue, so a single conditional subtract is a full reduction.
  function automatic logic [W-1:0] reduce_once(input logic [W-1:0] v);
    logic [W:0] ext;
    ext = {1'b0, v};
    return (ext >= MOD_W1) ? W'(ext - MOD_W1) : v;
  endfunction

  assign accept       = (state == IDLE) && in_valid;
  assign coef_addr_ok = (int'(coef_addr) < TAPS);

  // Both operands are already reduced, so the running sum stays below
  // 2*MOD and one conditional subtract keeps acc within 0..MOD-1.
  assign prod     = {{W{1'b0}}, x[k]} * {{W{1'b0}}, h[k]};
  assign prod_mod = W'(prod % MOD_P);
  assign sum_ext  = {1'b0, acc} + {1'b0, prod_mod};
  assign acc_next = (sum_ext >= MOD_W1) ? W'(sum_ext - MOD_W1) : sum_ext[W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = MAC;
      end
      MAC: begin
        if (k == K_LAST) next_state = WRITE;
      end
      WRITE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath. A coefficient write and a sample acceptance in the same IDLE
  // cycle both take effect; the new coefficient is in place before the first
  // MAC step reads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        res_mem[i] <= '0;
      end
      acc          <= '0;
      k            <= '0;
      wptr         <= '0;
      result_count <= '0;
      wrapped      <= 1'b0;
      done         <= 1'b0;
      reg_data     <= '0;
    end else begin
      done     <= (state == WRITE);
      reg_data <= res_mem[reg_addr];

      if ((state == IDLE) && coef_we && coef_addr_ok) begin
        h[coef_addr] <= reduce_once(coef_data);
      end

      if (accept) begin
        x[0] <= reduce_once(in_data);
        for (int i = 1; i < TAPS; i++) begin
          x[i] <= x[i-1];
        end
        acc <= '0;
        k   <= '0;
      end

      if (state == MAC) begin
        acc <= acc_next;
        k   <= k + KW'(1);
      end

      // DEPTH is a power of two, so the write pointer wraps on its own.
      if (state == WRITE) begin
        res_mem[wptr] <= acc;
        wptr          <= wptr + AW'(1);
        if (result_count == FULL) begin
          wrapped <= 1'b1;
        end else begin
          result_count <= result_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rns_fir_channel.sv
// tb_rns_fir_channel
// Self-checking bench for rns_fir_channel (MOD=7, TAPS=4, DEPTH=8). A
// behavioural model computes each result directly as sum(h[k]*x[n-k]) mod MOD
// at acceptance time and tracks channel occupancy as a countdown; a compare
// process checks every DUT output against it each cycle. Directed scenarios
// add hand-computed literal expectations.
module tb_rns_fir_channel;

  localparam int MOD   = 7;
  localparam int TAPS  = 4;
  localparam int DEPTH = 8;
  localparam int W     = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [W-1:0] in_data;
  logic       coef_we;
  logic [1:0] coef_addr;
  logic [W-1:0] coef_data;
  logic [2:0] reg_addr;
  logic [W-1:0] reg_data;
  logic       done;
  logic [3:0] result_count;
  logic       wrapped;

  always #5 clk = ~clk;

  rns_fir_channel #(.MOD(MOD), .TAPS(TAPS), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .reg_addr     (reg_addr),
    .reg_data     (reg_data),
    .done         (done),
    .result_count (result_count),
    .wrapped      (wrapped)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural model
  int m_h    [TAPS];
  int m_hist [TAPS];
  int m_mem  [DEPTH];
  int m_wptr, m_count, m_busy, m_pending, m_rd, m_y, m_done_total;
  bit m_wrapped, m_done, m_started;
  int cycle = 0;

  always @(posedge clk) begin
    cycle++;
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        m_h[i]    = 0;
        m_hist[i] = 0;
      end
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
      m_wptr    = 0;
      m_count   = 0;
      m_busy    = 0;
      m_rd      = 0;
      m_wrapped = 0;
      m_done    = 0;
      m_started = 1;
    end else begin
      m_rd   = m_mem[reg_addr];
      m_done = 0;
      if (m_busy == 0) begin
        if (coef_we) m_h[coef_addr] = int'(coef_data) % MOD;
        if (in_valid) begin
          for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
          m_hist[0] = int'(in_data) % MOD;
          m_y = 0;
          for (int i = 0; i < TAPS; i++) m_y += m_h[i] * m_hist[i];
          m_pending = m_y % MOD;
          m_busy    = TAPS + 1;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_mem[m_wptr] = m_pending;
          if (m_count == DEPTH) m_wrapped = 1;
          else m_count++;
          m_wptr = (m_wptr + 1) % DEPTH;
          m_done = 1;
          m_done_total++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus DUT-side event logging
  int dut_done_total = 0;
  int dut_acc[$];

  always @(negedge clk) begin
    if (m_started) begin
      checkOutput("in_ready", int'(in_ready), int'(m_busy == 0));
      checkOutput("done", int'(done), int'(m_done));
      checkOutput("result_count", int'(result_count), m_count);
      checkOutput("wrapped", int'(wrapped), int'(m_wrapped));
      checkOutput("reg_data", int'(reg_data), m_rd);
      if (in_valid && in_ready && !reset) dut_acc.push_back(cycle);
      if (done) dut_done_total++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic applyReset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic waitIdle;
    int n = 0;
    while (in_ready !== 1'b1 && n < 30) begin
      tick;
      n++;
    end
    checkOutput("idle_wait", int'(in_ready === 1'b1), 1);
  endtask

  task automatic writeCoef(input int a, input int d);
    waitIdle;
    coef_we   = 1'b1;
    coef_addr = 2'(a);
    coef_data = W'(d);
    tick;
    coef_we = 1'b0;
  endtask

  task automatic applyStimulus(input int d, input bit cwe, input int ca, input int cd);
    waitIdle;
    in_valid  = 1'b1;
    in_data   = W'(d);
    coef_we   = cwe;
    coef_addr = 2'(ca);
    coef_data = W'(cd);
    tick;
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic readCheck(input string name, input int a, input int expected);
    reg_addr = 3'(a);
    tick;
    checkOutput(name, int'(reg_data), expected);
  endtask

  int base_done;
  int seq_b [5] = '{6, 6, 6, 6, 7};
  int exp_b [5] = '{1, 2, 3, 4, 3};
  int exp_c [4] = '{3, 6, 2, 5};

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    reg_addr  = '0;
    applyReset;
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_count", int'(result_count), 0);
    checkOutput("reset_wrapped", int'(wrapped), 0);

    // Impulse response with h = 1,2,3,4
    base_done = dut_done_total;
    for (int i = 0; i < TAPS; i++) writeCoef(i, i + 1);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    waitIdle;
    for (int i = 0; i < 4; i++) begin
      checkOutput("impulse_model", m_mem[i], i + 1);
      readCheck("impulse_buf", i, i + 1);
    end
    checkOutput("impulse_done_pulses", dut_done_total - base_done, 4);
    checkOutput("impulse_count", int'(result_count), 4);
    checkOutput("impulse_wrapped", int'(wrapped), 0);

    // Modular arithmetic: all h = 6, inputs 6,6,6,6 then 7 (reduced to 0)
    applyReset;
    for (int i = 0; i < TAPS; i++) writeCoef(i, 6);
    for (int i = 0; i < 5; i++) applyStimulus(seq_b[i], 0, 0, 0);
    waitIdle;
    for (int i = 0; i < 5; i++) begin
      checkOutput("modwrap_model", m_mem[i], exp_b[i]);
      readCheck("modwrap_buf", i, exp_b[i]);
    end

    // Handshake: in_valid held high continuously
    applyReset;
    for (int i = 0; i < TAPS; i++) writeCoef(i, 1);
    dut_acc.delete();
    in_valid = 1'b1;
    in_data  = W'(3);
    repeat (20) tick;
    in_valid = 1'b0;
    waitIdle;
    checkOutput("hs_accepts", dut_acc.size(), 4);
    for (int i = 1; i < dut_acc.size(); i++)
      checkOutput("hs_spacing", dut_acc[i] - dut_acc[i-1], TAPS + 2);
    for (int i = 0; i < 4; i++) readCheck("hs_buf", i, exp_c[i]);

    // Buffer wrap: nine samples, the ninth lands in entry 0
    applyReset;
    for (int i = 0; i < TAPS; i++) writeCoef(i, i + 1);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0);
    waitIdle;
    checkOutput("wrap8_wrapped", int'(wrapped), 0);
    checkOutput("wrap8_count", int'(result_count), 8);
    applyStimulus(2, 0, 0, 0);
    waitIdle;
    checkOutput("wrap9_wrapped", int'(wrapped), 1);
    checkOutput("wrap9_count", int'(result_count), 8);
    checkOutput("wrap9_model", m_mem[0], 2);
    readCheck("wrap9_buf0", 0, 2);
    readCheck("wrap9_buf1", 1, 2);
    readCheck("wrap9_buf3", 3, 4);

    // Coefficient write during MAC is dropped; same-cycle IDLE write is used
    applyReset;
    writeCoef(0, 1);
    applyStimulus(3, 0, 0, 0);
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = W'(5);
    tick;
    coef_we = 1'b0;
    applyStimulus(2, 0, 0, 0);
    applyStimulus(1, 1, 0, 4);
    waitIdle;
    readCheck("coef_first", 0, 3);
    readCheck("coef_mac_drop", 1, 2);
    readCheck("coef_same_cycle", 2, 4);

    // Reset on the second MAC cycle aborts the computation
    applyReset;
    for (int i = 0; i < TAPS; i++) writeCoef(i, i + 1);
    base_done = dut_done_total;
    applyStimulus(1, 0, 0, 0);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checkOutput("abort_in_ready", int'(in_ready), 1);
    repeat (TAPS + 2) tick;
    checkOutput("abort_no_done", dut_done_total - base_done, 0);
    checkOutput("abort_count", int'(result_count), 0);
    for (int i = 0; i < DEPTH; i++) readCheck("abort_buf", i, 0);
    applyStimulus(1, 0, 0, 0);
    waitIdle;
    readCheck("abort_next", 0, 0);
    checkOutput("abort_next_count", int'(result_count), 1);

    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
